// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the VGA pixel path.
//   - visible-area origin (H_START/V_START) and tile geometry
//   - 2-bit tile type encodings stored in the tile map
//   - 12-bit {R,G,B} colour constants used by the renderer
//   - renderer FSM state type
package vga_pkg;

  localparam int H_START   = 144;
  localparam int V_START   = 35;
  localparam int TILE_BITS = 5;
  localparam int MAP_W     = 20;
  localparam int MAP_H     = 15;

  typedef enum logic [1:0] {
    TILE_EMPTY = 2'd0,
    TILE_HARD  = 2'd1,
    TILE_SOFT  = 2'd2,
    TILE_BOMB  = 2'd3
  } tile_t;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } renderState_t;

  localparam logic [11:0] COL_BLACK     = 12'h000;
  localparam logic [11:0] COL_PLAYER    = 12'hFF0;
  localparam logic [11:0] COL_EMPTY     = 12'h080;
  localparam logic [11:0] COL_HARD      = 12'h888;
  localparam logic [11:0] COL_HARD_EDGE = 12'h444;
  localparam logic [11:0] COL_SOFT      = 12'hA62;
  localparam logic [11:0] COL_BOMB      = 12'hF00;
  localparam logic [11:0] COL_BOMB_RIM  = 12'h111;

endpackage

// File: rtl/tile_map_ram.sv
// tile_map_ram: single-clock tile store, one write port, one registered
// read port, read-before-write on an address collision.
//   clk    - clock
//   we     - write enable (writes at or above DEPTH are dropped)
//   wrAddr - write address
//   wrData - 2-bit tile type to store
//   rdAddr - read address, sampled every clock
//   rdData - registered read data (old contents on a same-edge write)
module tile_map_ram #(
  parameter int DEPTH = 300,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wrAddr,
  input  logic [1:0]    wrData,
  input  logic [AW-1:0] rdAddr,
  output logic [1:0]    rdData
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (32'(wrAddr) < DEPTH)) begin
      mem[wrAddr] <= wrData;
    end
    rdData <= (32'(rdAddr) < DEPTH) ? mem[rdAddr] : '0;
  end

endmodule

// File: rtl/tile_renderer.sv
// tile_renderer: three-stage pixel pipeline after display_controller.
// Draws a 20x15 map of 32x32 tiles plus one 32x32 player square.
//   clk, rst_n          - clock, synchronous active-low reset
//   hCount, vCount      - raster counters
//   hSync_in, vSync_in  - raw syncs, delayed 3 clocks to hSync/vSync
//   map_we/addr/wdata   - tile map write port (addr = row*20+col)
//   player_x, player_y  - player top-left in visible-pixel coordinates
//   init_done           - high once the post-reset map clear finishes
//   vgaR, vgaG, vgaB    - registered 4-bit colour, aligned with syncs
module tile_renderer
  import vga_pkg::*;
#(
  parameter int H_START = vga_pkg::H_START,
  parameter int V_START = vga_pkg::V_START,
  parameter int MAP_W   = vga_pkg::MAP_W,
  parameter int MAP_H   = vga_pkg::MAP_H
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       hSync_in,
  input  logic       vSync_in,
  input  logic       map_we,
  input  logic [8:0] map_addr,
  input  logic [1:0] map_wdata,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic       init_done,
  output logic       hSync,
  output logic       vSync,
  output logic [3:0] vgaR,
  output logic [3:0] vgaG,
  output logic [3:0] vgaB
);

  localparam int         MAP_SIZE  = MAP_W * MAP_H;
  localparam logic [9:0] H_FIRST   = 10'(H_START);
  localparam logic [9:0] H_END     = 10'(H_START + 640);
  localparam logic [9:0] V_FIRST   = 10'(V_START);
  localparam logic [9:0] V_END     = 10'(V_START + 480);
  localparam logic [8:0] LAST_ADDR = 9'(MAP_SIZE - 1);

  renderState_t state;
  logic [8:0]   clearAddr;

  // Stage 1 combinational decode
  logic       visible;
  logic [9:0] px, py, dx, dy;
  logic [4:0] row, col;
  logic [8:0] rdAddrNext;
  logic       hitNext;

  // Pipeline registers
  logic                 s1Visible, s1Hit;
  logic [TILE_BITS-1:0] s1Lx, s1Ly;
  logic [8:0]           s1Addr;
  logic                 s2Visible, s2Hit;
  logic [TILE_BITS-1:0] s2Lx, s2Ly;
  logic [2:0]           hSyncPipe, vSyncPipe;

  // RAM ports
  logic       ramWe;
  logic [8:0] ramWrAddr;
  logic [1:0] ramWrData;
  logic [1:0] ramRdData;

  logic [11:0] pixelColour;

  always_comb begin
    px      = hCount - H_FIRST;
    py      = vCount - V_FIRST;
    visible = (hCount >= H_FIRST) && (hCount < H_END) &&
              (vCount >= V_FIRST) && (vCount < V_END);
    col     = px[9:TILE_BITS];
    row     = py[9:TILE_BITS];
    // row*20 + col as shifts; off-screen pixels read address 0 to stay in range
    rdAddrNext = visible ? ({row, 4'b0000} + {2'b00, row, 2'b00} + {4'b0000, col}) : '0;
    // A player edge right of / below the pixel borrows to a large value: miss.
    dx      = px - player_x;
    dy      = py - player_y;
    hitNext = (dx < 10'd32) && (dy < 10'd32);
  end

  always_comb begin
    if (state == ST_CLEAR) begin
      ramWe     = 1'b1;
      ramWrAddr = clearAddr;
      ramWrData = TILE_EMPTY;
    end else begin
      ramWe     = map_we && (map_addr <= LAST_ADDR);
      ramWrAddr = map_addr;
      ramWrData = map_wdata;
    end
  end

  tile_map_ram #(
    .DEPTH(MAP_SIZE),
    .AW   (9)
  ) u_tileMap (
    .clk   (clk),
    .we    (ramWe),
    .wrAddr(ramWrAddr),
    .wrData(ramWrData),
    .rdAddr(s1Addr),
    .rdData(ramRdData)
  );

  always_comb begin
    pixelColour = COL_BLACK;
    if (s2Visible && (state == ST_RUN)) begin
      if (s2Hit) begin
        pixelColour = COL_PLAYER;
      end else begin
        case (tile_t'(ramRdData))
          TILE_EMPTY: pixelColour = COL_EMPTY;
          TILE_HARD:  pixelColour = ((s2Lx == '0) || (s2Lx == '1) ||
                                     (s2Ly == '0) || (s2Ly == '1)) ? COL_HARD_EDGE : COL_HARD;
          TILE_SOFT:  pixelColour = COL_SOFT;
          TILE_BOMB:  pixelColour = ((s2Lx >= 5'd8) && (s2Lx <= 5'd23) &&
                                     (s2Ly >= 5'd8) && (s2Ly <= 5'd23)) ? COL_BOMB : COL_BOMB_RIM;
          default:    pixelColour = COL_BLACK;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_CLEAR;
      clearAddr <= '0;
      init_done <= 1'b0;
      s1Visible <= 1'b0;
      s1Hit     <= 1'b0;
      s1Lx      <= '0;
      s1Ly      <= '0;
      s1Addr    <= '0;
      s2Visible <= 1'b0;
      s2Hit     <= 1'b0;
      s2Lx      <= '0;
      s2Ly      <= '0;
      hSyncPipe <= '1;
      vSyncPipe <= '1;
      vgaR      <= '0;
      vgaG      <= '0;
      vgaB      <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clearAddr <= clearAddr + 9'd1;
          if (clearAddr == LAST_ADDR) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_CLEAR;
      endcase

      s1Visible <= visible;
      s1Hit     <= hitNext;
      s1Lx      <= px[TILE_BITS-1:0];
      s1Ly      <= py[TILE_BITS-1:0];
      s1Addr    <= rdAddrNext;

      s2Visible <= s1Visible;
      s2Hit     <= s1Hit;
      s2Lx      <= s1Lx;
      s2Ly      <= s1Ly;

      {vgaR, vgaG, vgaB} <= pixelColour;

      hSyncPipe <= {hSyncPipe[1:0], hSync_in};
      vSyncPipe <= {vSyncPipe[1:0], vSync_in};
    end
  end

  assign hSync = hSyncPipe[2];
  assign vSync = vSyncPipe[2];

endmodule

// File: doc/tile_renderer.md
Name: tile_renderer

Overview:
- Pixel stage directly downstream of display_controller.
- Consumes hCount/vCount/hSync/vSync and produces registered vgaR/G/B plus delayed syncs for the Bomberman playfield.
- Holds a 20x15 tile map (32x32-pixel tiles, 2-bit tile type) written by game logic, and overlays one 32x32 player square.
- Three-stage pipeline; syncs are delayed to match, so colour and sync stay aligned at the pins.

Parameters:
- H_START, 144, first visible hCount.
- V_START, 35, first visible vCount.
- MAP_W, 20, tiles per row.
- MAP_H, 15, tile rows.

Ports:
- clk  in  1  system clock, same as display_controller.
- rst_n  in  1  synchronous active-low reset.
- hCount  in  10  horizontal counter from display_controller.
- vCount  in  10  vertical counter from display_controller.
- hSync_in  in  1  raw hSync.
- vSync_in  in  1  raw vSync.
- map_we  in  1  tile write strobe.
- map_addr  in  9  tile index, row*20+col.
- map_wdata  in  2  tile type: 0 EMPTY, 1 HARD, 2 SOFT, 3 BOMB.
- player_x  in  10  player left edge, visible-pixel coordinates (0..639).
- player_y  in  10  player top edge (0..479).
- init_done  out  1  high once map clear is complete.
- hSync  out  1  hSync_in delayed 3 cycles.
- vSync  out  1  vSync_in delayed 3 cycles.
- vgaR, vgaG, vgaB  out  4 each  pixel colour.

Behaviour:
- Reset, sampled on the clk edge while rst_n=0:
  - All outputs go to 0, except hSync/vSync pipes, which load 1 (idle high).
  - FSM enters CLEAR with clear_addr=0.
- FSM CLEAR:
  - Each cycle writes EMPTY to clear_addr and increments it.
  - After writing addr 299, moves to RUN and sets init_done=1 on that same edge, 300 cycles after reset release.
  - In CLEAR, map_we is ignored and RGB is forced to 0. Syncs still pipe through.
- FSM RUN: stays in RUN until rst_n=0. Reset mid-operation restarts CLEAR.
- Stage 1 (register):
  - visible = hCount in [H_START, H_START+640) and vCount in [V_START, V_START+480).
  - px = hCount-H_START and py = vCount-V_START, 10-bit, valid only when visible.
  - col = px[9:5], row = py[9:5].
  - rd_addr = (row<<4)+(row<<2)+col.
  - Register lx = px[4:0], ly = py[4:0].
  - Register the player hit: px-player_x < 32 and py-player_y < 32, unsigned compare on 10-bit differences. Borrow from a negative difference yields a miss.
- Stage 2: synchronous RAM read of rd_addr. lx, ly, visible and hit ride alongside.
- Stage 3: registered colour select, in priority order:
  1. !visible or CLEAR -> 000.
  2. hit -> F,F,0.
  3. EMPTY -> 0,8,0.
  4. HARD -> 8,8,8; border pixels (lx or ly = 0 or 31) -> 4,4,4.
  5. SOFT -> A,6,2.
  6. BOMB -> F,0,0 when lx and ly both in 8..23, else 1,1,1.
- Latency: exactly 3 clk cycles from counter/sync inputs to outputs.
- Map writes in RUN:
  - map_we with map_addr >= 300 is ignored.
  - Write and read to the same address in the same cycle: the read returns old data (read-before-write).
  - A write takes effect for reads issued on the following cycle.
- player_x/player_y are sampled every cycle with no latching. Callers update them during vertical blank to avoid tearing.
- Player square partly off-screen: only the visible portion is drawn. No wrap-around, because of the borrow rule above.

Decomposition:
- Shared package vga_pkg holds:
  - TILE_EMPTY/HARD/SOFT/BOMB encodings.
  - 12-bit colour constants.
  - H_START, V_START, TILE_BITS=5, MAP_W, MAP_H.
- One sub-module: tile_map_ram.
  - 300x2 single-clock RAM with one write port and one registered read port, read-before-write.
  - Inferrable as distributed/block RAM.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, release -> init_done rises exactly 300 cycles later; RGB=0 throughout CLEAR; map_we pulses during CLEAR do not change the map.
- Empty map: drive hCount=144, vCount=35 -> 3 cycles later RGB=0,8,0; hCount=143 -> RGB=0,0,0.
- HARD tile: write addr 21 = HARD, then address pixel px=32, py=32 (hCount=176, vCount=67) -> RGB=4,4,4; px=40, py=40 -> 8,8,8.
- BOMB tile and out-of-range write: write addr 0 = BOMB and addr 300 = SOFT -> px=16, py=16 gives F,0,0; px=2, py=2 gives 1,1,1; no aliasing from addr 300.
- Player overlay: player_x=620, player_y=470 -> px=639, py=479 gives F,F,0; px=619 gives tile colour; player_x=0 and px=639 give no hit.
- Sync alignment and hazards:
  - Toggle hSync_in on a single cycle -> hSync toggles exactly 3 cycles later.
  - Same-cycle write/read of addr 5 -> output shows old type, and the next pixel read shows the new type.
